// File: rtl/sram_mem_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sram_mem_controller
//  Description : MEM-stage data-memory responder. Each 32-bit load or store
//                runs as two 16-bit accesses (low half, then high half) on an
//                external asynchronous SRAM. ready stays low while an access
//                is in flight and is used by the pipeline as a stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_mem_controller #(
  parameter int DATA_W    = 32,
  parameter int SRAM_AW   = 18,
  parameter int SRAM_DW   = 16,
  parameter int BASE_ADDR = 1024,
  parameter int WAIT_CYC  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [DATA_W-1:0]  address,
  input  logic [DATA_W-1:0]  write_data,
  output logic [DATA_W-1:0]  read_data,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  // Word index width: one SRAM address bit selects the half-word.
  localparam int C_IDX_W = SRAM_AW - 1;
  localparam int C_CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST_CNT = C_CNT_W'(WAIT_CYC - 1);
  localparam logic [DATA_W-1:0]  C_BASE     = DATA_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic [C_IDX_W-1:0]   addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic                 op_wr_q;
  logic [DATA_W-1:0]    rdata_q;

  logic                 w_req;
  logic                 w_last;
  logic [DATA_W-1:0]    w_offset;
  logic [C_IDX_W-1:0]   w_idx;
  logic                 w_unused_bits;
  logic                 w_we_n;
  logic                 w_drive;
  logic [SRAM_AW-1:0]   w_sram_addr;
  logic [SRAM_DW-1:0]   w_dq_out;

  assign w_req  = wr_en | rd_en;
  assign w_last = (cnt_q == C_LAST_CNT);

  // Byte offset from the SRAM window; wraps mod 2^DATA_W, byte lane bits and
  // bits above the index range are dropped so out-of-range addresses alias.
  assign w_offset      = address - C_BASE;
  assign w_idx         = w_offset[C_IDX_W+1:2];
  assign w_unused_bits = ^{w_offset[DATA_W-1:C_IDX_W+2], w_offset[1:0]};

  // Next-state and wait-counter logic; counter restarts on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end
      end
      S_LOW: begin
        if (w_last) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + C_CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (w_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + C_CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // SRAM bus drive: address and write data only during the two half phases.
  always_comb begin
    w_we_n      = 1'b1;
    w_drive     = 1'b0;
    w_sram_addr = '0;
    w_dq_out    = '0;
    if ((state_q == S_LOW) || (state_q == S_HIGH)) begin
      w_sram_addr = {addr_q, (state_q == S_HIGH)};
      if (op_wr_q) begin
        w_we_n   = 1'b0;
        w_drive  = 1'b1;
        w_dq_out = (state_q == S_HIGH) ? wdata_q[DATA_W-1:SRAM_DW]
                                       : wdata_q[SRAM_DW-1:0];
      end
    end
  end

  // State register, request latch and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Write wins when both requests arrive together.
      if ((state_q == S_IDLE) && w_req) begin
        addr_q  <= w_idx;
        wdata_q <= write_data;
        op_wr_q <= wr_en;
      end
      // Sample the bus at the end of the last wait cycle of each read half.
      if (!op_wr_q && w_last) begin
        if (state_q == S_LOW) begin
          rdata_q[SRAM_DW-1:0] <= SRAM_DQ;
        end
        if (state_q == S_HIGH) begin
          rdata_q[DATA_W-1:SRAM_DW] <= SRAM_DQ;
        end
      end
    end
  end

  assign SRAM_DQ   = w_drive ? w_dq_out : {SRAM_DW{1'bz}};
  assign SRAM_ADDR = w_sram_addr;
  assign SRAM_WE_N = w_we_n;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign read_data = rdata_q;
  assign ready     = ~w_req | (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sram_mem_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_mem_controller
//  Description : Directed, table-driven bench for sram_mem_controller with a
//                behavioural asynchronous SRAM model on the data bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_mem_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, ce_n, oe_n, ub_n, lb_n;

  int checks = 0;
  int errors = 0;

  sram_mem_controller #(
    .DATA_W(32), .SRAM_AW(18), .SRAM_DW(16), .BASE_ADDR(1024), .WAIT_CYC(2)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: drives the bus whenever not being written.
  logic [15:0] mem [0:(1<<18)-1];
  logic        model_en = 1'b0;
  assign sram_dq = (model_en && we_n) ? mem[sram_addr] : 16'hzzzz;
  always @(posedge clk) if (!we_n) mem[sram_addr] <= sram_dq;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_ready;
    logic        exp_we_n;
    logic [17:0] exp_sa;
    logic        chk_dq;
    logic [15:0] exp_dq;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // An undriven bus reads as all-z, or as zero in a two-state simulator.
  task automatic chk_released(input string name);
    checks++;
    if (!(sram_dq === 16'hzzzz || sram_dq === 16'h0000)) begin
      errors++;
      $display("FAIL %s: bus got %h expected released (z)", name, sram_dq);
    end
  endtask

  task automatic add(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                     input logic er, input logic ew, input logic [17:0] esa,
                     input logic cdq, input logic [15:0] edq, input logic [31:0] erd);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.wdata = d;
    v.exp_ready = er; v.exp_we_n = ew; v.exp_sa = esa;
    v.chk_dq = cdq; v.exp_dq = edq; v.exp_rd = erd;
    vq.push_back(v);
  endtask

  // One full access (cycles 0..5) followed by one idle cycle. With garble set,
  // address/data change while the access is in flight and must be ignored.
  task automatic add_access(input logic wr, input logic rd, input logic [31:0] a,
                            input logic [31:0] d, input logic [17:0] sa_lo,
                            input logic [15:0] dq_lo, input logic [15:0] dq_hi,
                            input logic [31:0] rd0, input logic [31:0] rd_mid,
                            input logic [31:0] rd_fin, input bit garble);
    logic [31:0] ga, gd;
    ga = garble ? 32'hFFFF_0000 : a;
    gd = garble ? 32'h0000_0000 : d;
    add(wr, rd, a,  d,  1'b0, 1'b1, 18'd0,       1'b0, 16'h0, rd0);
    add(wr, rd, a,  d,  1'b0, ~wr,  sa_lo,       wr,   dq_lo, rd0);
    add(wr, rd, ga, gd, 1'b0, ~wr,  sa_lo,       wr,   dq_lo, rd0);
    add(wr, rd, ga, gd, 1'b0, ~wr,  sa_lo+18'd1, wr,   dq_hi, rd_mid);
    add(wr, rd, ga, gd, 1'b0, ~wr,  sa_lo+18'd1, wr,   dq_hi, rd_mid);
    add(wr, rd, a,  d,  1'b1, 1'b1, 18'd0,       1'b0, 16'h0, rd_fin);
    add(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 18'd0, 1'b0, 16'h0, rd_fin);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      wr_en = vq[i].wr; rd_en = vq[i].rd;
      address = vq[i].addr; write_data = vq[i].wdata;
      @(negedge clk);
      chk($sformatf("%s[%0d] ready", tag, i), {31'b0, ready}, {31'b0, vq[i].exp_ready});
      chk($sformatf("%s[%0d] we_n", tag, i), {31'b0, we_n}, {31'b0, vq[i].exp_we_n});
      chk($sformatf("%s[%0d] sram_addr", tag, i), {14'b0, sram_addr}, {14'b0, vq[i].exp_sa});
      chk($sformatf("%s[%0d] read_data", tag, i), read_data, vq[i].exp_rd);
      if (vq[i].chk_dq)
        chk($sformatf("%s[%0d] dq", tag, i), {16'b0, sram_dq}, {16'b0, vq[i].exp_dq});
      @(posedge clk); #1;
    end
    vq.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle with the SRAM model silent: bus must be released by the DUT.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle[%0d] ready", i), {31'b0, ready}, 32'd1);
      chk($sformatf("idle[%0d] we_n", i), {31'b0, we_n}, 32'd1);
      chk($sformatf("idle[%0d] sram_addr", i), {14'b0, sram_addr}, 32'd0);
      chk($sformatf("idle[%0d] read_data", i), read_data, 32'd0);
      chk_released($sformatf("idle[%0d] dq", i));
      @(posedge clk); #1;
    end
    chk("tie-offs", {28'b0, ce_n, oe_n, ub_n, lb_n}, 32'd0);

    model_en = 1'b1;
    add_access(1, 0, 32'd1024, 32'hDEADBEEF, 18'd0, 16'hBEEF, 16'hDEAD,
               32'h0, 32'h0, 32'h0, 0);
    add_access(0, 1, 32'd1024, 32'h0, 18'd0, 16'h0, 16'h0,
               32'h0, 32'h0000BEEF, 32'hDEADBEEF, 0);
    add_access(1, 0, 32'd1028, 32'h12345678, 18'd2, 16'h5678, 16'h1234,
               32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1);
    add_access(1, 1, 32'd1032, 32'hCAFEF00D, 18'd4, 16'hF00D, 16'hCAFE,
               32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    add_access(0, 1, 32'd1028, 32'h0, 18'd2, 16'h0, 16'h0,
               32'hDEADBEEF, 32'hDEAD5678, 32'h12345678, 1);
    add_access(0, 1, 32'd1032, 32'h0, 18'd4, 16'h0, 16'h0,
               32'h12345678, 32'h1234F00D, 32'hCAFEF00D, 0);
    add_access(1, 0, 32'd525312, 32'h0000FFFF, 18'd0, 16'hFFFF, 16'h0000,
               32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 0);
    add_access(0, 1, 32'd525312, 32'h0, 18'd0, 16'h0, 16'h0,
               32'hCAFEF00D, 32'hCAFEFFFF, 32'h0000FFFF, 0);
    run_table("tbl");

    // Reset during the HIGH phase of a store.
    model_en = 1'b0;
    wr_en = 1'b1; address = 32'd1024; write_data = 32'h11112222;
    @(negedge clk);
    chk("rst c0 ready", {31'b0, ready}, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst c3 we_n", {31'b0, we_n}, 32'd0);
    chk("rst c3 sram_addr", {14'b0, sram_addr}, 32'd1);
    chk("rst c3 dq", {16'b0, sram_dq}, 32'h1111);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    chk("rst c4 ready", {31'b0, ready}, 32'd1);
    chk("rst c4 we_n", {31'b0, we_n}, 32'd1);
    chk("rst c4 sram_addr", {14'b0, sram_addr}, 32'd0);
    chk("rst c4 read_data", read_data, 32'd0);
    chk_released("rst c4 dq");
    @(posedge clk); #1;

    // Load after the abandoned store sees both halves that reached the SRAM.
    model_en = 1'b1;
    add_access(0, 1, 32'd1024, 32'h0, 18'd0, 16'h0, 16'h0,
               32'h0, 32'h00002222, 32'h11112222, 0);
    run_table("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
